mem_access_unit: RTL and testbench

//   Parametrised sequential load/store unit between the MEM stage and a synchronous-read data RAM.

---
 rtl/mem_access_unit.sv | 189 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and a synchronous-read data RAM.
// One access at a time: sub-word stores are read-modify-write, misaligned requests fault.
module mem_access_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_misalign,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int SH_W  = OFF_W + 3;

    typedef enum logic [2:0] {IDLE, RD_WAIT, WRITE, RESP, FAULT} state_t;
    state_t state_reg, state_next;

    logic              accept;
    logic              misalign_in;
    logic              full_in;
    logic [2:0]        off_in;
    logic [ADDR_W-1:0] word_addr_in;

    logic              we_reg;
    logic              signed_reg;
    logic [1:0]        size_reg;
    logic [OFF_W-1:0]  off_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [CNT_W-1:0]  cnt_reg;

    logic [SH_W-1:0]   sh_amt;
    logic [DATA_W-1:0] lane_mask;
    logic [DATA_W-1:0] lane_top;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] load_ext;
    logic [DATA_W-1:0] merged;

    assign accept       = req_valid && (state_reg == IDLE);
    assign off_in       = 3'(req_addr[OFF_W-1:0]);
    assign word_addr_in = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign full_in      = (int'(req_size) == OFF_W);

    always_comb begin
        misalign_in = 1'b0;
        case (req_size)
            2'b00:   misalign_in = 1'b0;
            2'b01:   misalign_in = off_in[0];
            2'b10:   misalign_in = |off_in[1:0];
            default: misalign_in = (DATA_W == 32) || (|off_in);
        endcase
    end

    // Lane extraction and merge both work on a mask of the access size
    // positioned at the byte offset of the latched address.
    assign sh_amt = {off_reg, 3'b000};

    always_comb begin
        lane_mask = '1;
        case (size_reg)
            2'b00:   lane_mask = DATA_W'(8'hFF);
            2'b01:   lane_mask = DATA_W'(16'hFFFF);
            2'b10:   lane_mask = DATA_W'(32'hFFFF_FFFF);
            default: lane_mask = '1;
        endcase
    end

    assign lane_top = lane_mask & ~(lane_mask >> 1);
    assign shifted  = mem_rdata >> sh_amt;
    assign load_ext = (shifted & lane_mask)
                    | ((signed_reg && (|(shifted & lane_top))) ? ~lane_mask : '0);
    assign merged   = (mem_rdata & ~(lane_mask << sh_amt))
                    | ((wdata_reg & lane_mask) << sh_amt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (misalign_in)            state_next = FAULT;
                    else if (req_we && full_in) state_next = WRITE;
                    else                        state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt_reg == '0) state_next = we_reg ? WRITE : RESP;
            end
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            FAULT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The RAM sees the request address in the accept cycle so that read
    // data lines up with the RD_LAT-cycle wait that follows.
    always_comb begin
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_misalign = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = mem_addr_reg;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid && !misalign_in) mem_addr = word_addr_in;
            end
            WRITE: mem_we = 1'b1;
            RESP:  resp_valid = 1'b1;
            FAULT: begin
                resp_valid    = 1'b1;
                resp_misalign = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_reg        <= 1'b0;
            signed_reg    <= 1'b0;
            size_reg      <= 2'b00;
            off_reg       <= '0;
            wdata_reg     <= '0;
            rdata_reg     <= '0;
            mem_wdata_reg <= '0;
            mem_addr_reg  <= '0;
            cnt_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        we_reg     <= req_we;
                        signed_reg <= req_signed;
                        size_reg   <= req_size;
                        off_reg    <= req_addr[OFF_W-1:0];
                        wdata_reg  <= req_wdata;
                        cnt_reg    <= CNT_W'(RD_LAT - 1);
                        if (misalign_in) begin
                            rdata_reg <= '0;
                        end else begin
                            mem_addr_reg <= word_addr_in;
                            if (req_we && full_in) mem_wdata_reg <= req_wdata;
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt_reg == '0) begin
                        if (we_reg) mem_wdata_reg <= merged;
                        else        rdata_reg     <= load_ext;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                WRITE:   rdata_reg <= '0;
                default: ;
            endcase
        end
    end

    assign resp_rdata = rdata_reg;
    assign mem_wdata  = mem_wdata_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a 32-bit/RD_LAT=1 and a 64-bit/RD_LAT=3 instance,
// each against its own RAM and a byte-addressed reference memory.
module tb_mem_access_unit;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_we     = 1'b0;
    logic        req_signed = 1'b0;
    logic [1:0]  req_size   = 2'b00;
    logic [31:0] req_addr   = '0;
    logic [63:0] req_wdata  = '0;
    logic        v32 = 1'b0;
    logic        v64 = 1'b0;

    logic        rdy32, rv32, mis32, we32;
    logic [31:0] rd32, ma32, wd32, mr32;
    logic        rdy64, rv64, mis64, we64;
    logic [63:0] rd64, wd64, mr64;
    logic [31:0] ma64;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .RD_LAT(1)) u32 (
        .clk(clk), .rst_n(rst_n), .req_valid(v32), .req_ready(rdy32),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .resp_valid(rv32), .resp_rdata(rd32), .resp_misalign(mis32),
        .mem_addr(ma32), .mem_rdata(mr32), .mem_we(we32), .mem_wdata(wd32)
    );

    mem_access_unit #(.DATA_W(64), .ADDR_W(32), .RD_LAT(3)) u64 (
        .clk(clk), .rst_n(rst_n), .req_valid(v64), .req_ready(rdy64),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv64), .resp_rdata(rd64), .resp_misalign(mis64),
        .mem_addr(ma64), .mem_rdata(mr64), .mem_we(we64), .mem_wdata(wd64)
    );

    // RAM models: 0x800 bytes each, with a backdoor preload port.
    logic        bk_we  = 1'b0;
    logic [8:0]  bk_idx = '0;
    logic [31:0] bk32   = '0;
    logic [63:0] bk64   = '0;
    logic [31:0] ram32 [0:511];
    logic [63:0] ram64 [0:255];
    logic [31:0] p32;
    logic [63:0] p64 [0:2];

    always @(posedge clk) begin
        if (bk_we) ram32[bk_idx] <= bk32;
        else if (we32) ram32[ma32[10:2]] <= wd32;
        p32 <= ram32[ma32[10:2]];
    end
    assign mr32 = p32;

    always @(posedge clk) begin
        if (bk_we && !bk_idx[8]) ram64[bk_idx[7:0]] <= bk64;
        else if (we64) ram64[ma64[10:3]] <= wd64;
        p64[0] <= ram64[ma64[10:3]];
        p64[1] <= p64[0];
        p64[2] <= p64[1];
    end
    assign mr64 = p64[2];

    logic [7:0] ref_b [0:1][0:2047];
    int checks   = 0;
    int failures = 0;
    int rc;
    logic [63:0] got;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_word(input int c, input int widx);
        int wb = (c == 1) ? 8 : 4;
        logic [63:0] w = '0;
        for (int i = 0; i < wb; i++) w |= 64'(ref_b[c][widx * wb + i]) << (8 * i);
        return w;
    endfunction

    function automatic logic [63:0] ref_load(input int c, input int addr, input int size, input bit sgn);
        int n = 1 << size;
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v |= 64'(ref_b[c][addr + i]) << (8 * i);
        if (sgn && n < 8 && v[8 * n - 1]) v |= ~((64'd1 << (8 * n)) - 64'd1);
        if (c == 0) v = {32'd0, v[31:0]};
        return v;
    endfunction

    task automatic put32(input int c, input int addr, input logic [31:0] v);
        for (int i = 0; i < 4; i++) ref_b[c][addr + i] = v[8 * i +: 8];
    endtask

    // One request, started just after a falling edge; k counts cycles after the accept edge.
    task automatic access(input int c, input bit we, input int size, input bit sgn,
                          input int addr, input logic [63:0] wd, input string tag,
                          output logic [63:0] rdata);
        int n, lat, wb, widx, exp_resp, exp_wecyc, resp_cyc, we_cyc, we_cnt;
        bit mis;
        logic [63:0] exp_rd, lowbits;
        logic got_mis, rdy_resp;
        n   = 1 << size;
        lat = (c == 1) ? 3 : 1;
        wb  = (c == 1) ? 8 : 4;
        mis = ((addr % n) != 0) || (c == 0 && size == 3);
        exp_rd = '0;
        exp_wecyc = -1;
        if (mis) exp_resp = 0;
        else if (!we) begin
            exp_resp = lat;
            exp_rd = ref_load(c, addr, size, sgn);
        end else if (n == wb) begin
            exp_wecyc = 0;
            exp_resp = 1;
        end else begin
            exp_wecyc = lat;
            exp_resp = lat + 1;
        end
        chk({tag, "/ready_pre"}, 64'((c == 1) ? rdy64 : rdy32), 64'd1);
        req_we = we; req_size = 2'(size); req_signed = sgn;
        req_addr = 32'(addr); req_wdata = wd;
        if (c == 1) v64 = 1'b1; else v32 = 1'b1;
        @(posedge clk); #1;
        v32 = 1'b0; v64 = 1'b0;
        req_addr = $urandom(); req_wdata = {$urandom(), $urandom()};
        req_size = 2'($urandom()); req_we = ~we; req_signed = ~sgn;
        resp_cyc = -1; we_cyc = -1; we_cnt = 0; rdata = '0;
        got_mis = 1'b0; rdy_resp = 1'b0; lowbits = '0;
        for (int k = 0; k < 24 && resp_cyc < 0; k++) begin
            @(negedge clk);
            lowbits |= (c == 1) ? 64'(ma64[2:0]) : 64'(ma32[1:0]);
            if ((c == 1) ? we64 : we32) begin
                we_cnt++;
                we_cyc = k;
            end
            if ((c == 1) ? rv64 : rv32) begin
                resp_cyc = k;
                rdata    = (c == 1) ? rd64 : 64'(rd32);
                got_mis  = (c == 1) ? mis64 : mis32;
                rdy_resp = (c == 1) ? rdy64 : rdy32;
            end
        end
        chk({tag, "/resp_lat"}, 64'(resp_cyc), 64'(exp_resp));
        chk({tag, "/rdata"}, rdata, exp_rd);
        chk({tag, "/misalign"}, 64'(got_mis), 64'(mis));
        chk({tag, "/we_cnt"}, 64'(we_cnt), 64'((exp_wecyc >= 0) ? 1 : 0));
        chk({tag, "/we_cyc"}, 64'(we_cyc), 64'(exp_wecyc));
        chk({tag, "/ready_in_resp"}, 64'(rdy_resp), 64'd0);
        chk({tag, "/addr_align"}, lowbits, 64'd0);
        if (we && !mis)
            for (int i = 0; i < n; i++) ref_b[c][addr + i] = wd[8 * i +: 8];
        widx = addr / wb;
        chk({tag, "/ram"}, (c == 1) ? ram64[widx] : 64'(ram32[widx]), ref_word(c, widx));
        @(negedge clk);
        chk({tag, "/post_valid"}, 64'((c == 1) ? rv64 : rv32), 64'd0);
        chk({tag, "/post_mis"}, 64'((c == 1) ? mis64 : mis32), 64'd0);
        chk({tag, "/post_ready"}, 64'((c == 1) ? rdy64 : rdy32), 64'd1);
        $display("txn %s cfg=%0d we=%0d size=%0d signed=%0d addr=%0h rdata=%0h misalign=%0d lat=%0d",
                 tag, c, we, size, sgn, addr, rdata, got_mis, resp_cyc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 2048; i++) ref_b[c][i] = 8'($urandom());
        for (int c = 0; c < 2; c++) begin
            put32(c, 'h100, 32'h8899AABB);
            put32(c, 'h200, 32'h11223344);
        end
        put32(1, 'h8, 32'h89ABCDEF);
        put32(1, 'hC, 32'hF1234567);

        for (int i = 0; i < 512; i++) begin
            bk_idx = 9'(i);
            bk32   = 32'(ref_word(0, i));
            bk64   = ref_word(1, i % 256);
            bk_we  = 1'b1;
            @(posedge clk); #1;
        end
        bk_we = 1'b0;

        @(negedge clk);
        chk("reset/ready32", 64'(rdy32), 64'd1);
        chk("reset/valid32", 64'(rv32), 64'd0);
        chk("reset/mis32", 64'(mis32), 64'd0);
        chk("reset/we32", 64'(we32), 64'd0);
        chk("reset/rdata32", 64'(rd32), 64'd0);
        chk("reset/addr32", 64'(ma32), 64'd0);
        chk("reset/wdata32", 64'(wd32), 64'd0);
        chk("reset/ready64", 64'(rdy64), 64'd1);
        chk("reset/we64", 64'(we64), 64'd0);
        chk("reset/rdata64", rd64, 64'd0);
        rst_n = 1'b1;

        access(0, 0, 0, 1, 'h101, '0, "t1_lb_s32", got);
        chk("t1_const32", got, 64'hFFFF_FFAA);
        access(0, 0, 1, 0, 'h102, '0, "t2_lhu32", got);
        chk("t2u_const32", got, 64'h0000_8899);
        access(0, 0, 1, 1, 'h102, '0, "t2_lhs32", got);
        chk("t2s_const32", got, 64'hFFFF_8899);
        access(0, 1, 0, 0, 'h203, 64'hEE, "t3_sb32", got);
        chk("t3_ram_const32", 64'(ram32['h80]), 64'hEE22_3344);
        access(0, 1, 2, 0, 'h204, 64'hCAFEF00D, "t4_sw32", got);
        chk("t4_ram_const32", 64'(ram32['h81]), 64'hCAFE_F00D);
        access(0, 0, 1, 0, 'h301, '0, "t5_mis_h32", got);
        access(0, 0, 2, 0, 'h302, '0, "t5_mis_w32", got);
        access(0, 0, 3, 0, 'h300, '0, "t5_dw_on32", got);
        access(0, 1, 1, 0, 'h301, 64'hBEEF, "t5_mis_sh32", got);

        access(1, 0, 0, 1, 'h101, '0, "t1_lb_s64", got);
        chk("t1_const64", got, 64'hFFFF_FFFF_FFFF_FFAA);
        access(1, 0, 1, 0, 'h102, '0, "t2_lhu64", got);
        chk("t2u_const64", got, 64'h0000_0000_0000_8899);
        access(1, 0, 1, 1, 'h102, '0, "t2_lhs64", got);
        access(1, 1, 0, 0, 'h203, 64'hEE, "t3_sb64", got);
        access(1, 0, 2, 0, 'h200, '0, "t3_rb64", got);
        chk("t3_const64", got, 64'h0000_0000_EE22_3344);
        access(1, 0, 3, 1, 'h8, '0, "t_ld64", got);
        chk("t_ld_const64", got, 64'hF123_4567_89AB_CDEF);
        access(1, 1, 3, 0, 'h208, 64'h0123_4567_89AB_CDEF, "t_sd64", got);
        access(1, 0, 3, 0, 'h104, '0, "t_mis_d64", got);
        access(1, 0, 2, 1, 'h104, '0, "t_lw_hi64", got);

        // Reset in the middle of a sub-word store's read wait.
        req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h10D; req_wdata = 64'h5A; v64 = 1'b1;
        @(posedge clk); #1;
        v64 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid/ready", 64'(rdy64), 64'd1);
        chk("rst_mid/valid", 64'(rv64), 64'd0);
        chk("rst_mid/we", 64'(we64), 64'd0);
        chk("rst_mid/addr", 64'(ma64), 64'd0);
        chk("rst_mid/rdata32", 64'(rd32), 64'd0);
        rc = 0;
        repeat (4) begin
            @(negedge clk);
            if (we64) rc++;
        end
        rst_n = 1'b1;
        chk("rst_mid/we_cnt", 64'(rc), 64'd0);
        chk("rst_mid/ram", ram64['h10D / 8], ref_word(1, 'h10D / 8));
        $display("txn rst_mid cfg=1 we_pulses=%0d ready=%0d", rc, rdy64);

        for (int r = 0; r < 80; r++) begin
            int c, size, addr, n;
            bit we, sgn;
            c    = r & 1;
            size = $urandom_range(0, 3);
            n    = 1 << size;
            addr = $urandom_range(0, 2040);
            if ($urandom_range(0, 3) != 0) addr = addr & ~(n - 1);
            we   = 1'($urandom_range(0, 1));
            sgn  = 1'($urandom_range(0, 1));
            access(c, we, size, sgn, addr, {$urandom(), $urandom()}, "rnd", got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
